// File: rtl/gsim_x_writeback_if.sv
// Result-SRAM write bus: show-ahead request (wen/addr/data) with a ready handshake.
// The writeback block drives the request as master; the SRAM side answers with ready.
interface gsim_x_writeback_if #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 32
);
  logic          sram_wen;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_data;
  logic          sram_ready;

  modport master (
    output sram_wen,
    output sram_addr,
    output sram_data,
    input  sram_ready
  );

  modport slave (
    input  sram_wen,
    input  sram_addr,
    input  sram_data,
    output sram_ready
  );
endinterface

// File: rtl/gsim_x_writeback.sv
// Buffers solver x results in a show-ahead FIFO and drains them to the result SRAM,
// checking address order and counting committed 16-entry vectors.
module gsim_x_writeback #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 9,
  parameter int unsigned DW    = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_module_en,
  input  logic [4:0]             i_matrix_num,
  input  logic                   i_x_wen,
  input  logic [AW-1:0]          i_x_addr,
  input  logic [DW-1:0]          i_x_data,
  gsim_x_writeback_if.master     sram,
  output logic                   o_full,
  output logic                   o_overflow,
  output logic                   o_seq_err,
  output logic                   o_vec_done,
  output logic [4:0]             o_vec_cnt,
  output logic                   o_all_done
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] L_FULL_CNT = (PW + 1)'(DEPTH);

  logic [AW+DW-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;
  logic [AW-1:0]    r_exp_addr;
  logic [3:0]       r_commit_cnt;
  logic [4:0]       r_vec_cnt;
  logic             r_vec_done;
  logic             r_overflow;
  logic             r_seq_err;
  logic             r_all_done;

  logic             w_not_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic [AW+DW-1:0] w_head;

  assign w_not_empty = (r_count != '0);
  assign w_full      = (r_count == L_FULL_CNT);
  // A pop frees a slot at the same edge, so a push into a full FIFO is still accepted.
  assign w_pop       = i_module_en && w_not_empty && sram.sram_ready;
  assign w_push      = i_module_en && i_x_wen && (!w_full || w_pop);
  assign w_head      = r_mem[r_rptr];

  // Gate the head with not-empty so stale storage never appears on the bus.
  assign sram.sram_wen  = w_not_empty;
  assign sram.sram_addr = w_not_empty ? w_head[AW+DW-1:DW] : '0;
  assign sram.sram_data = w_not_empty ? w_head[DW-1:0] : '0;

  assign o_full     = w_full;
  assign o_overflow = r_overflow;
  assign o_seq_err  = r_seq_err;
  assign o_vec_done = r_vec_done;
  assign o_vec_cnt  = r_vec_cnt;
  assign o_all_done = r_all_done;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {i_x_addr, i_x_data};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_exp_addr   <= '0;
      r_commit_cnt <= '0;
      r_vec_cnt    <= '0;
      r_vec_done   <= 1'b0;
      r_overflow   <= 1'b0;
      r_seq_err    <= 1'b0;
      r_all_done   <= 1'b0;
    end else if (!i_module_en) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_exp_addr   <= '0;
      r_commit_cnt <= '0;
      r_vec_cnt    <= '0;
      r_vec_done   <= 1'b0;
      r_overflow   <= 1'b0;
      r_seq_err    <= 1'b0;
      r_all_done   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count <= r_count + (PW + 1)'(w_push) - (PW + 1)'(w_pop);

      if (i_x_wen && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end

      if (w_push) begin
        if (i_x_addr != r_exp_addr) begin
          r_seq_err <= 1'b1;
        end
        r_exp_addr <= i_x_addr + 1'b1;
      end

      r_vec_done <= w_pop && (r_commit_cnt == 4'hf);
      if (w_pop) begin
        r_commit_cnt <= r_commit_cnt + 1'b1;
        if ((r_commit_cnt == 4'hf) && (r_vec_cnt != 5'd31)) begin
          r_vec_cnt <= r_vec_cnt + 1'b1;
        end
      end

      if ((r_vec_cnt == i_matrix_num) && (i_matrix_num != 5'd0)) begin
        r_all_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gsim_x_writeback.sv
// Randomized and directed bench for gsim_x_writeback against a queue-based reference model.
module tb_gsim_x_writeback;
  localparam int DEPTH = 8;
  localparam int AW    = 9;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [4:0]    num = 5'd0;
  logic          wen = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data = '0;
  logic          ready = 1'b0;
  logic          full, ov, se, vd, ad;
  logic [4:0]    vcnt;

  int checks = 0;
  int errors = 0;

  gsim_x_writeback_if #(.AW(AW), .DW(DW)) sif ();
  assign sif.sram_ready = ready;

  gsim_x_writeback #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_module_en  (en),
    .i_matrix_num (num),
    .i_x_wen      (wen),
    .i_x_addr     (addr),
    .i_x_data     (data),
    .sram         (sif),
    .o_full       (full),
    .o_overflow   (ov),
    .o_seq_err    (se),
    .o_vec_done   (vd),
    .o_vec_cnt    (vcnt),
    .o_all_done   (ad)
  );

  always #5 clk = ~clk;

  // Reference model state: what the outputs must be after the most recent edge.
  logic [AW+DW-1:0] mq[$];
  int m_exp, m_commits, m_vec_cnt;
  bit m_ov, m_se, m_vd, m_ad, m_pop, m_push;

  // Observed SRAM writes and vector-done pulses.
  logic [AW+DW-1:0] wlog[$];
  int wr_cnt = 0;
  int vd_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mclear();
    mq.delete();
    m_exp = 0; m_commits = 0; m_vec_cnt = 0;
    m_ov = 0; m_se = 0; m_vd = 0; m_ad = 0;
  endtask

  task automatic model_step();
    if (!rst_n || !en) begin
      mclear();
    end else begin
      m_pop  = (mq.size() > 0) && ready;
      m_push = wen && ((mq.size() < DEPTH) || m_pop);
      if ((m_vec_cnt == int'(num)) && (num != 0)) m_ad = 1;
      m_vd = 0;
      if (m_pop) begin
        void'(mq.pop_front());
        m_commits++;
        if (m_commits % 16 == 0) begin
          m_vd = 1;
          if (m_vec_cnt < 31) m_vec_cnt++;
        end
      end
      if (wen && !m_push) m_ov = 1;
      if (m_push) begin
        if (int'(addr) != m_exp) m_se = 1;
        m_exp = (int'(addr) + 1) % (1 << AW);
        mq.push_back({addr, data});
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    logic [AW+DW-1:0] head;
    logic             exp_wen;
    forever begin
      @(negedge clk);
      exp_wen = (mq.size() != 0);
      head    = exp_wen ? mq[0] : '0;
      chk("sram_wen", 64'(sif.sram_wen), 64'(exp_wen));
      chk("sram_addr", 64'(sif.sram_addr), 64'(head[AW+DW-1:DW]));
      chk("sram_data", 64'(sif.sram_data), 64'(head[DW-1:0]));
      chk("full", 64'(full), 64'(mq.size() == DEPTH));
      chk("overflow", 64'(ov), 64'(m_ov));
      chk("seq_err", 64'(se), 64'(m_se));
      chk("vec_done", 64'(vd), 64'(m_vd));
      chk("vec_cnt", 64'(vcnt), 64'(m_vec_cnt));
      chk("all_done", 64'(ad), 64'(m_ad));
      if (sif.sram_wen && ready) begin
        wr_cnt++;
        wlog.push_back({sif.sram_addr, sif.sram_data});
      end
      if (vd) vd_cnt++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic soft_clear();
    en = 0; wen = 0;
    tick();
    en = 1;
  endtask

  task automatic push_one(input int a, input int d);
    wen = 1; addr = AW'(a); data = DW'(d);
    tick();
    wen = 0;
  endtask

  task automatic drain();
    ready = 1;
    for (int i = 0; i < 300 && sif.sram_wen; i++) tick();
    chk("drain_done", 64'(sif.sram_wen), 64'(0));
  endtask

  initial begin
    int base, vbase, a, n, seq_a;
    mclear();
    repeat (3) tick();
    chk("reset_wen", 64'(sif.sram_wen), 64'(0));
    chk("reset_cnt", 64'(vcnt), 64'(0));
    en = 1;
    rst_n = 1;

    // Back-to-back vector with ready held high; first push right after release.
    ready = 1; base = wr_cnt; vbase = vd_cnt;
    for (int i = 0; i < 16; i++) begin
      wen = 1; addr = AW'(i); data = DW'(32'h100 + i);
      tick();
    end
    wen = 0;
    drain();
    tick(); tick();
    chk("s1_writes", 64'(wr_cnt - base), 64'(16));
    chk("s1_vec_done_pulses", 64'(vd_cnt - vbase), 64'(1));
    chk("s1_vec_cnt", 64'(vcnt), 64'(1));
    for (int i = 0; i < 16; i++)
      chk("s1_order", 64'(wlog[base + i]), {23'd0, AW'(i), DW'(32'h100 + i)});

    // Overflow when full with no drain.
    soft_clear();
    ready = 0;
    for (int i = 0; i < 8; i++) push_one(i, 32'h200 + i);
    chk("s2_full", 64'(full), 64'(1));
    chk("s2_no_ov_yet", 64'(ov), 64'(0));
    push_one(8, 32'h208);
    chk("s2_overflow", 64'(ov), 64'(1));
    base = wr_cnt;
    drain();
    chk("s2_writes", 64'(wr_cnt - base), 64'(8));
    chk("s2_last_addr", 64'(wlog[wr_cnt - 1][AW+DW-1:DW]), 64'(7));

    // Push into a full FIFO together with a pop.
    soft_clear();
    ready = 0;
    for (int i = 0; i < 8; i++) push_one(i, 32'h300 + i);
    wen = 1; addr = AW'(8); data = DW'(32'h308); ready = 1;
    tick();
    wen = 0; ready = 0;
    chk("s3_full", 64'(full), 64'(1));
    chk("s3_no_ov", 64'(ov), 64'(0));
    chk("s3_head", 64'(sif.sram_addr), 64'(1));
    drain();

    // Address gap.
    soft_clear();
    ready = 1; base = wr_cnt;
    push_one(0, 1);
    push_one(1, 2);
    chk("s4_seq_ok", 64'(se), 64'(0));
    push_one(3, 3);
    chk("s4_seq_err", 64'(se), 64'(1));
    drain();
    chk("s4_writes", 64'(wr_cnt - base), 64'(3));

    // Two vectors with ready toggling; the pusher respects o_full.
    soft_clear();
    num = 5'd2; ready = 0; a = 0; n = 0;
    while (a < 32 && n < 300) begin
      ready = ~ready;
      if (!full || ready) begin
        wen = 1; addr = AW'(a); data = DW'(32'h400 + a); a++;
      end else begin
        wen = 0;
      end
      tick();
      n++;
    end
    wen = 0;
    chk("s5_pushed", 64'(a), 64'(32));
    drain();
    tick(); tick();
    chk("s5_vec_cnt", 64'(vcnt), 64'(2));
    chk("s5_all_done", 64'(ad), 64'(1));

    // Reset mid-operation with 5 buffered entries.
    soft_clear();
    num = 0; ready = 0;
    push_one(0, 5); push_one(1, 6); push_one(2, 7); push_one(3, 8); push_one(9, 9);
    chk("s6_prefill_se", 64'(se), 64'(1));
    #1 rst_n = 0;
    mclear();
    #1;
    chk("s6_rst_wen", 64'(sif.sram_wen), 64'(0));
    chk("s6_rst_addr", 64'(sif.sram_addr), 64'(0));
    chk("s6_rst_data", 64'(sif.sram_data), 64'(0));
    chk("s6_rst_flags", {59'd0, full, ov, se, vd, ad}, 64'(0));
    chk("s6_rst_vcnt", 64'(vcnt), 64'(0));
    tick();
    rst_n = 1;
    ready = 1; base = wr_cnt;
    repeat (6) tick();
    chk("s6_no_writes", 64'(wr_cnt - base), 64'(0));

    // Randomized traffic checked cycle by cycle against the model.
    soft_clear();
    seq_a = 0;
    for (int c = 0; c < 3000; c++) begin
      en    = ($urandom % 60) != 0;
      wen   = ($urandom % 3) != 0;
      ready = ($urandom % 2) != 0;
      addr  = (($urandom % 10) == 0) ? AW'($urandom) : AW'(seq_a);
      data  = $urandom;
      if (wen) seq_a = (int'(addr) + 1) % (1 << AW);
      if (($urandom % 150) == 0) num = 5'($urandom_range(0, 3));
      if (($urandom % 700) == 0) begin
        rst_n = 0;
        mclear();
        tick();
        rst_n = 1;
      end else begin
        tick();
      end
    end
    wen = 0;
    drain();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
